// File: rtl/hwpe_ctrl_package.sv
// Shared types for the HWPE control slice: microcode loop engine records
// and the issuer FSM encoding.
package hwpe_ctrl_package;

    localparam int unsigned ULOOP_MAX_NB_LOOPS = 6;
    localparam int unsigned ULOOP_MAX_NB_REG   = 4;
    localparam int unsigned ULOOP_CNT_WIDTH    = 12;
    localparam int unsigned ULOOP_OFFS_WIDTH   = 32;

    typedef struct packed {
        logic enable;
        logic clear;
        logic ready;
    } ctrl_uloop_t;

    typedef struct packed {
        logic                                                done;
        logic                                                valid;
        logic [ULOOP_MAX_NB_REG-1:0][ULOOP_OFFS_WIDTH-1:0]   offs;
        logic [ULOOP_MAX_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0]  idx;
        logic [ULOOP_MAX_NB_LOOPS-1:0]                       idx_update;
    } flags_uloop_t;

    typedef enum logic [2:0] {
        ULI_IDLE,
        ULI_CLEAR,
        ULI_REQ,
        ULI_WAIT,
        ULI_ISSUE,
        ULI_DONE
    } uloop_issuer_state_t;

endpackage

// File: rtl/hwpe_ctrl_uloop_issuer.sv
// Steps the microcode loop engine one iteration at a time and turns each
// returned offset set into a base+offset address request for the streamers.
module hwpe_ctrl_uloop_issuer
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_STREAMS = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic                                  start_i,
    input  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] base_addr_i,
    output ctrl_uloop_t                           uloop_ctrl_o,
    input  flags_uloop_t                          uloop_flags_i,
    output logic                                  req_valid_o,
    input  logic                                  req_ready_i,
    output logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] req_addr_o,
    output logic [ULOOP_MAX_NB_LOOPS-1:0]         req_idx_update_o,
    output logic                                  req_last_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [CNT_WIDTH-1:0]                  nb_issued_o
);

    uloop_issuer_state_t r_state, w_state_next;

    logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] r_base;
    logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] w_addr;
    logic [ULOOP_MAX_NB_LOOPS-1:0]         r_idx_update;
    logic                                  r_last;
    logic [CNT_WIDTH-1:0]                  r_nb_issued;

    logic w_start;
    logic w_capture;
    logic w_accept;
    logic w_unused;

    assign w_start   = (r_state == ULI_IDLE)  && start_i;
    assign w_capture = (r_state == ULI_WAIT)  && uloop_flags_i.valid;
    assign w_accept  = (r_state == ULI_ISSUE) && req_ready_i;

    // Only the offsets of the first NB_STREAMS registers feed the adders.
    assign w_unused = ^uloop_flags_i;

    // Offsets are cast to the address width, so the sum wraps naturally.
    for (genvar g = 0; g < NB_STREAMS; g++) begin : gen_adder
        assign w_addr[g] = r_base[g] + ADDR_WIDTH'(uloop_flags_i.offs[g]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ULI_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = ULI_IDLE;
        end else begin
            case (r_state)
                ULI_IDLE:  if (start_i) w_state_next = ULI_CLEAR;
                ULI_CLEAR: w_state_next = ULI_REQ;
                ULI_REQ:   w_state_next = ULI_WAIT;
                ULI_WAIT:  if (uloop_flags_i.valid) w_state_next = ULI_ISSUE;
                ULI_ISSUE: if (req_ready_i) w_state_next = r_last ? ULI_DONE : ULI_REQ;
                ULI_DONE:  w_state_next = ULI_IDLE;
                default:   w_state_next = ULI_IDLE;
            endcase
        end
    end

    // clear_i reaches the engine in the same cycle so it aborts alongside us.
    always_comb begin
        busy_o              = (r_state != ULI_IDLE);
        req_valid_o         = (r_state == ULI_ISSUE);
        done_o              = (r_state == ULI_DONE);
        uloop_ctrl_o.enable = (r_state == ULI_REQ);
        uloop_ctrl_o.clear  = (r_state == ULI_CLEAR) || clear_i;
        uloop_ctrl_o.ready  = busy_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base       <= '0;
            r_addr       <= '0;
            r_idx_update <= '0;
            r_last       <= 1'b0;
            r_nb_issued  <= '0;
        end else if (clear_i) begin
            r_base       <= '0;
            r_addr       <= '0;
            r_idx_update <= '0;
            r_last       <= 1'b0;
        end else begin
            if (w_start) begin
                r_base      <= base_addr_i;
                r_nb_issued <= '0;
            end
            if (w_capture) begin
                r_addr       <= w_addr;
                r_idx_update <= uloop_flags_i.idx_update;
                r_last       <= uloop_flags_i.done;
            end
            if (w_accept) r_nb_issued <= r_nb_issued + CNT_WIDTH'(1);
        end
    end

    assign req_addr_o       = r_addr;
    assign req_idx_update_o = r_idx_update;
    assign req_last_o       = r_last;
    assign nb_issued_o      = r_nb_issued;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_issuer.sv
// Scoreboard bench: a behavioural loop-engine responder drives the flags,
// expected requests are queued per nest and checked by a negedge monitor.
module tb_hwpe_ctrl_uloop_issuer;
    import hwpe_ctrl_package::*;

    localparam int NB = 4;
    localparam int AW = 32;
    localparam int CW = 16;

    typedef logic [NB-1:0][AW-1:0] vec_t;
    typedef struct {
        vec_t       addr;
        logic [5:0] iu;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    logic start_i = 1'b0;
    logic req_ready_i = 1'b0;
    vec_t base_addr_i = '0;
    ctrl_uloop_t  uloop_ctrl_o;
    flags_uloop_t uloop_flags_i = '0;
    logic req_valid_o, req_last_o, busy_o, done_o;
    vec_t req_addr_o;
    logic [ULOOP_MAX_NB_LOOPS-1:0] req_idx_update_o;
    logic [CW-1:0] nb_issued_o;

    hwpe_ctrl_uloop_issuer #(.NB_STREAMS(NB), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .uloop_ctrl_o(uloop_ctrl_o), .uloop_flags_i(uloop_flags_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .req_idx_update_o(req_idx_update_o), .req_last_o(req_last_o), .busy_o(busy_o),
        .done_o(done_o), .nb_issued_o(nb_issued_o)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int n_pass = 0, n_total = 0;
    int unsigned p_range = 1;
    vec_t p_stride = '0;
    int ready_mode = 1;
    bit noise_en = 0;
    int hold_after = 1000;
    int acc_cnt = 0, enable_cnt = 0, done_cnt = 0, clear_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Loop engine stand-in: one iteration per enable, reply one cycle later
    // (optionally delayed), with spurious flags when noise is enabled.
    initial begin
        int iter, pend, dly;
        iter = 0; pend = 0; dly = 0;
        forever begin
            @(posedge clk); #1;
            uloop_flags_i = '0;
            if (noise_en) begin
                for (int i = 0; i < NB; i++) uloop_flags_i.offs[i] = $urandom;
                uloop_flags_i.done = 1'($urandom_range(0, 1));
            end
            if (uloop_ctrl_o.clear) begin
                iter = 0; pend = 0;
            end else if (pend != 0 && iter < hold_after) begin
                if (dly == 0) begin
                    uloop_flags_i.valid = 1'b1;
                    uloop_flags_i.done  = (iter == int'(p_range) - 1);
                    for (int i = 0; i < NB; i++) uloop_flags_i.offs[i] = 32'(iter) * p_stride[i];
                    uloop_flags_i.idx_update = (iter == int'(p_range) - 1) ? 6'h3 : 6'h1;
                    iter++; pend = 0;
                end else dly--;
            end
            if (uloop_ctrl_o.enable) begin
                pend = 1;
                dly = noise_en ? int'($urandom_range(0, 2)) : 0;
            end
            if (noise_en && req_valid_o && $urandom_range(0, 1) == 1) uloop_flags_i.valid = 1'b1;
        end
    end

    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge clk); #1;
            if (acc_cnt == 0) stall = 0;
            case (ready_mode)
                0: req_ready_i = ($urandom_range(0, 2) != 0);
                2: if (req_valid_o && acc_cnt == 1 && stall < 5) begin
                       req_ready_i = 1'b0; stall++;
                   end else req_ready_i = 1'b1;
                3: req_ready_i = 1'b0;
                default: req_ready_i = 1'b1;
            endcase
        end
    end

    initial begin
        bit want_done, busy_chk, prev_stall, h_last;
        vec_t h_addr;
        exp_t e;
        want_done = 0; busy_chk = 0; prev_stall = 0; h_last = 0; h_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                want_done = 0; busy_chk = 0; prev_stall = 0; acc_cnt = 0;
                continue;
            end
            if (busy_chk) begin
                check("busy_low_after_done", busy_o, 0);
                busy_chk = 0;
            end
            if (want_done) begin
                check("done_pulse", done_o, 1);
                check("nb_issued", nb_issued_o, p_range);
                check("enable_pulses", enable_cnt, p_range);
                want_done = 0; busy_chk = 1; done_cnt++;
            end else if (done_o) check("spurious_done", done_o, 0);
            if (uloop_ctrl_o.clear) begin
                clear_cnt++; acc_cnt = 0; enable_cnt = 0; prev_stall = 0;
            end else begin
                if (uloop_ctrl_o.enable) enable_cnt++;
                if (req_valid_o) begin
                    if (prev_stall) begin
                        check("hold_addr", req_addr_o, h_addr);
                        check("hold_last", req_last_o, h_last);
                    end
                    if (req_ready_i) begin
                        if (exp_q.size() == 0) check("unexpected_req", 1, 0);
                        else begin
                            e = exp_q.pop_front();
                            check("req_addr", req_addr_o, e.addr);
                            check("req_idx_update", req_idx_update_o, e.iu);
                            check("req_last", req_last_o, e.last);
                            if (e.last) want_done = 1;
                        end
                        acc_cnt++; prev_stall = 0;
                    end else begin
                        prev_stall = 1; h_addr = req_addr_o; h_last = req_last_o;
                    end
                end else prev_stall = 0;
            end
        end
    end

    task automatic push_exp(input int n, input vec_t b, input vec_t s);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NB; i++) e.addr[i] = b[i] + 32'(k) * s[i];
            e.iu = (k == n - 1) ? 6'h3 : 6'h1;
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic setup(input int n, input vec_t b, input vec_t s, input int rmode, input bit noise);
        p_range = n; p_stride = s; ready_mode = rmode; noise_en = noise;
        base_addr_i = b;
        push_exp(n, b, s);
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin @(posedge clk); t++; end
        if (done_cnt == d0) begin
            check("nest_timeout", 0, 1);
            @(negedge clk); clear_i = 1'b1; @(negedge clk); clear_i = 1'b0;
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_nest(input int n, input vec_t b, input vec_t s, input int rmode,
                            input bit noise, input bit lat);
        int d0;
        d0 = done_cnt;
        setup(n, b, s, rmode, noise);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        for (int i = 0; i < NB; i++) base_addr_i[i] = $urandom;
        check("start_clear", uloop_ctrl_o.clear, 1);
        check("nb_zero_on_start", nb_issued_o, 0);
        if (lat) begin
            @(posedge clk); #1 check("enable_at_t2", uloop_ctrl_o.enable, 1);
            @(posedge clk); #1 check("wait_at_t3", {uloop_ctrl_o.enable, req_valid_o, busy_o}, 3'b001);
            @(posedge clk); #1 check("valid_at_t4", req_valid_o, 1);
        end
        wait_done(d0);
    endtask

    initial begin
        vec_t b, s;
        int d0, c0, t;

        #12;
        check("reset_outputs", {req_valid_o, req_last_o, busy_o, done_o, nb_issued_o,
                                req_idx_update_o, uloop_ctrl_o}, '0);
        check("reset_addr", req_addr_o, '0);
        @(negedge clk); rst_ni = 1'b1;

        // basic nest, then the same with a 5-cycle stall on request 2
        b = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
        s = {32'h4, 32'h0, 32'h8, 32'h10};
        run_nest(4, b, s, 1, 0, 1);
        run_nest(4, b, s, 2, 0, 0);

        // spurious flags: valid in ISSUE, done without valid in WAIT
        run_nest(5, b, s, 0, 1, 0);

        // address wrap
        run_nest(2, {4{32'hFFFF_FFF0}}, {4{32'h20}}, 1, 0, 0);

        // clear_i while a request is stalled
        setup(4, b, s, 2, 0);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!(req_valid_o && !req_ready_i && acc_cnt == 1) && t < 200);
        check("clear_setup_reached", t < 200, 1);
        #1 clear_i = 1'b1;
        #1 check("clear_passthrough", uloop_ctrl_o.clear, 1);
        @(posedge clk); #1 clear_i = 1'b0;
        check("clear_state", {busy_o, req_valid_o, req_last_o}, 3'b000);
        check("clear_addr", req_addr_o, '0);
        check("clear_nb_held", nb_issued_o, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        run_nest(3, b, s, 1, 0, 0);

        // start held for 10 cycles starts exactly one nest
        d0 = done_cnt; c0 = clear_cnt;
        setup(4, b, s, 1, 0);
        @(posedge clk); #1 start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1 start_i = 1'b0;
        wait_done(d0);
        check("single_clear_pulse", clear_cnt - c0, 1);
        check("single_done", done_cnt - d0, 1);

        // asynchronous reset while waiting for the second reply
        hold_after = 1;
        setup(4, b, s, 1, 0);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre_reset_nb", nb_issued_o, 1);
        #2 rst_ni = 1'b0;
        #1 check("async_reset_outputs", {req_valid_o, req_last_o, busy_o, done_o, nb_issued_o,
                                          req_idx_update_o, uloop_ctrl_o}, '0);
        check("async_reset_addr", req_addr_o, '0);
        exp_q.delete();
        @(negedge clk); @(negedge clk); rst_ni = 1'b1;
        hold_after = 1000;
        repeat (3) @(posedge clk);

        // randomized nests
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NB; i++) begin b[i] = $urandom; s[i] = $urandom; end
            run_nest(int'($urandom_range(1, 6)), b, s, 0, 1'($urandom_range(0, 1)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
